// File: rtl/acl_ctrl_pkg.sv
// Shared definitions for the accelerometer sample controller: axis and
// accumulator widths, the controller state encoding and a sign-extension
// helper used by the averaging datapath.
package acl_ctrl_pkg;

  localparam int AXIS_W = 10;
  localparam int ACC_W  = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } acl_state_t;

  // Widen one raw axis sample to accumulator width, preserving its sign.
  function automatic logic signed [ACC_W-1:0] sext_axis(input logic [AXIS_W-1:0] v);
    return {{(ACC_W-AXIS_W){v[AXIS_W-1]}}, v};
  endfunction

endpackage

// File: rtl/acl_tick_gen.sv
// Periodic sample tick generator. Runs only while EN is high, reloads on
// the rising edge of EN and pulses TICK for one cycle every SAMPLE_PERIOD
// cycles, the first pulse landing SAMPLE_PERIOD cycles after EN rises.
module acl_tick_gen #(
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             en_q;

  // Down-counter that restarts on EN rising and wraps after reaching zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= EN;
      if (EN) begin
        if (!en_q || (cnt == '0)) begin
          cnt <= RELOAD;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // A zero count only counts as a tick once the counter has been reloaded.
  assign TICK = EN && en_q && (cnt == '0);

endmodule

// File: rtl/acl_sample_ctrl.sv
// Accelerometer sample controller: launches one SPI read per sample tick,
// waits (bounded) for the SPI master to finish, and registers the axis data
// for the magnitude converter. Missed completions and overlapping ticks are
// flagged with sticky error bits.
// Build option: define ACL_AVG_EN to average every 4 captures before output.
module acl_sample_ctrl
  import acl_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int DONE_TIMEOUT  = 5000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic              SPI_START,
  input  logic              SPI_DONE,
  input  logic [AXIS_W-1:0] RX_X,
  input  logic [AXIS_W-1:0] RX_Y,
  output logic [AXIS_W-1:0] xAxis,
  output logic [AXIS_W-1:0] yAxis,
  output logic              DATA_VALID,
  output logic              TIMEOUT_ERR,
  output logic              OVERRUN
);

  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);

  acl_state_t        state;
  acl_state_t        state_next;
  logic              tick;
  logic [WAIT_W-1:0] wait_cnt;
  logic              capture;
  logic              timeout_hit;
  logic              overrun_hit;

  acl_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick_gen (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .TICK(tick)
  );

  // Controller state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the capture/timeout/overrun events it implies.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    overrun_hit = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_next = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (!EN) begin
          state_next = IDLE;
        end else if (tick) begin
          state_next = START;
        end
      end
      START: begin
        overrun_hit = tick;
        state_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        overrun_hit = tick;
        if (SPI_DONE) begin
          capture    = 1'b1;
          state_next = EN ? WAIT_TICK : IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = EN ? WAIT_TICK : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign SPI_START = (state == START);

  // Cycles spent waiting for SPI_DONE; held at zero outside WAIT_DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TIMEOUT_ERR <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      if (timeout_hit) begin
        TIMEOUT_ERR <= 1'b1;
      end
      if (overrun_hit) begin
        OVERRUN <= 1'b1;
      end
    end
  end

`ifdef ACL_AVG_EN

  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic [1:0]              acc_cnt;
  logic signed [ACC_W-1:0] sum_x;
  logic signed [ACC_W-1:0] sum_y;
  logic signed [ACC_W-1:0] avg_x;
  logic signed [ACC_W-1:0] avg_y;

  assign sum_x = acc_x + sext_axis(RX_X);
  assign sum_y = acc_y + sext_axis(RX_Y);
  assign avg_x = sum_x >>> 2;
  assign avg_y = sum_y >>> 2;

  // Sum four captures, then publish the floored mean and restart; a timeout
  // or a stay in IDLE discards any partial sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_x      <= '0;
      acc_y      <= '0;
      acc_cnt    <= '0;
      xAxis      <= '0;
      yAxis      <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (capture) begin
        if (acc_cnt == 2'd3) begin
          xAxis      <= avg_x[AXIS_W-1:0];
          yAxis      <= avg_y[AXIS_W-1:0];
          DATA_VALID <= 1'b1;
          acc_x      <= '0;
          acc_y      <= '0;
          acc_cnt    <= '0;
        end else begin
          acc_x   <= sum_x;
          acc_y   <= sum_y;
          acc_cnt <= acc_cnt + 1'b1;
        end
      end else if (timeout_hit || (state == IDLE)) begin
        acc_x   <= '0;
        acc_y   <= '0;
        acc_cnt <= '0;
      end
    end
  end

`else

  // Register each completed capture straight through to the outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xAxis      <= '0;
      yAxis      <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= capture;
      if (capture) begin
        xAxis <= RX_X;
        yAxis <= RX_Y;
      end
    end
  end

`endif

endmodule
